// File: rtl/poly_mul_ctrl.sv
// poly_mul_ctrl: pass sequencer for the Dilithium NTT/INTT/pointwise datapath.
// Walks the 64-word coefficient bank once per pass. It issues read
// address, datapath op, layer select and twiddle address, and produces
// latency-matched write-back strobes through an 8-deep delay line.
module poly_mul_ctrl #(
    parameter int LAT_NTT  = 5,
    parameter int LAT_INTT = 5,
    parameter int LAT_MUL  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] mode,
    output logic [2:0] sel,
    output logic [1:0] ntt_l,
    output logic [7:0] tf_address,
    output logic       rd_en,
    output logic [5:0] rd_addr,
    output logic       wr_en,
    output logic [5:0] wr_addr,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Tap index into the delay line is latency minus one (element 0 is delay 0)
    localparam logic [2:0] TAP_NTT  = 3'(LAT_NTT - 1);
    localparam logic [2:0] TAP_INTT = 3'(LAT_INTT - 1);
    localparam logic [2:0] TAP_MUL  = 3'(LAT_MUL - 1);

    state_t     state_r, state_s;
    logic [5:0] cnt_r, cnt_s;
    logic [1:0] pass_r, pass_s;
    logic [1:0] mode_r, mode_s;

    logic [2:0] sel_s, sel_r;
    logic [1:0] ntt_l_s, ntt_l_r;
    logic [7:0] tf_s, tf_r;
    logic       rd_en_s, rd_en_r;
    logic [5:0] rd_addr_s, rd_addr_r;
    logic       busy_s, busy_r;
    logic       done_s, done_r;
    logic       wr_en_r;
    logic [5:0] wr_addr_r;
    logic [7:0] dly_en_r;
    logic [5:0] dly_addr_r [8];
    logic [2:0] tap_s;

    // Datapath latency of a mode, expressed as delay-line tap index
    function automatic logic [2:0] tap_of(input logic [1:0] m);
        case (m)
            2'b00:   tap_of = TAP_NTT;
            2'b01:   tap_of = TAP_INTT;
            default: tap_of = TAP_MUL;
        endcase
    endfunction

    // Index of the final pass: three NTT/INTT layer groups, one pointwise pass
    function automatic logic [1:0] last_pass_of(input logic [1:0] m);
        last_pass_of = m[1] ? 2'd0 : 2'd2;
    endfunction

    // Layer group of pass p: ascending for NTT, descending for INTT
    function automatic logic [1:0] layer_of(input logic [1:0] m, input logic [1:0] p);
        case (m)
            2'b00:   layer_of = p;
            2'b01:   layer_of = 2'd2 - p;
            default: layer_of = 2'd2;
        endcase
    endfunction

    // Datapath operation code for a mode
    function automatic logic [2:0] sel_of(input logic [1:0] m);
        case (m)
            2'b00:   sel_of = 3'b001;
            2'b01:   sel_of = 3'b100;
            2'b10:   sel_of = 3'b010;
            default: sel_of = 3'b110;
        endcase
    endfunction

    assign tap_s = tap_of(mode_r);

    // State register: sequencer position, pass index and latched mode
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 6'd0;
            pass_r  <= 2'd0;
            mode_r  <= 2'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            pass_r  <= pass_s;
            mode_r  <= mode_s;
        end
    end

    // Next-state logic: 64 read cycles, then a latency-long drain, per pass
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        pass_s  = pass_r;
        mode_s  = mode_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_RUN;
                    mode_s  = mode;
                    pass_s  = 2'd0;
                    cnt_s   = 6'd0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == 6'd63) begin
                    state_s = ST_DRAIN;
                    cnt_s   = 6'd0;
                end else begin
                    cnt_s = cnt_r + 6'd1;
                end
            end
            ST_DRAIN: begin
                if (cnt_r == {3'b000, tap_s}) begin
                    cnt_s = 6'd0;
                    if (pass_r == last_pass_of(mode_r)) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_RUN;
                        pass_s  = pass_r + 2'd1;
                    end
                end else begin
                    cnt_s = cnt_r + 6'd1;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs line up with it
    always_comb begin
        sel_s     = 3'b000;
        ntt_l_s   = 2'd0;
        tf_s      = 8'd0;
        rd_en_s   = 1'b0;
        rd_addr_s = 6'd0;
        busy_s    = 1'b0;
        done_s    = 1'b0;
        case (state_s)
            ST_RUN: begin
                busy_s    = 1'b1;
                rd_en_s   = 1'b1;
                rd_addr_s = cnt_s;
                sel_s     = sel_of(mode_s);
                ntt_l_s   = layer_of(mode_s, pass_s);
                if (mode_s[1]) begin
                    tf_s = 8'd0;
                end else begin
                    case (ntt_l_s)
                        2'd0:    tf_s = {2'b00, cnt_s};
                        2'd1:    tf_s = 8'd63 + {3'b000, cnt_s[5:1]};
                        2'd2:    tf_s = 8'd127 + {3'b000, cnt_s[5:1]};
                        default: tf_s = 8'd0;
                    endcase
                end
            end
            ST_DRAIN: begin
                busy_s    = 1'b1;
                rd_addr_s = 6'd63;
                sel_s     = sel_of(mode_s);
                ntt_l_s   = layer_of(mode_s, pass_s);
            end
            ST_DONE: begin
                done_s = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            sel_r     <= 3'b000;
            ntt_l_r   <= 2'd0;
            tf_r      <= 8'd0;
            rd_en_r   <= 1'b0;
            rd_addr_r <= 6'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            sel_r     <= sel_s;
            ntt_l_r   <= ntt_l_s;
            tf_r      <= tf_s;
            rd_en_r   <= rd_en_s;
            rd_addr_r <= rd_addr_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
        end
    end

    // Write-back delay line: element k holds the read strobe/address from k cycles ago
    always_ff @(posedge clk) begin
        if (!rst) begin
            dly_en_r  <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                dly_addr_r[i] <= 6'd0;
            end
            wr_en_r   <= 1'b0;
            wr_addr_r <= 6'd0;
        end else begin
            dly_en_r      <= {dly_en_r[6:0], rd_en_s};
            dly_addr_r[0] <= rd_addr_s;
            for (int i = 1; i < 8; i++) begin
                dly_addr_r[i] <= dly_addr_r[i-1];
            end
            wr_en_r   <= dly_en_r[tap_s];
            wr_addr_r <= dly_addr_r[tap_s];
        end
    end

    assign sel        = sel_r;
    assign ntt_l      = ntt_l_r;
    assign tf_address = tf_r;
    assign rd_en      = rd_en_r;
    assign rd_addr    = rd_addr_r;
    assign wr_en      = wr_en_r;
    assign wr_addr    = wr_addr_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: tb/tb_poly_mul_ctrl.sv
// Self-checking bench for poly_mul_ctrl: table-driven mode runs, hand-written
// corner sequences and randomized runs, all compared cycle by cycle against a
// timeline model computed from pass length arithmetic.
module tb_poly_mul_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [2:0] sel;
    logic [1:0] ntt_l;
    logic [7:0] tf_address;
    logic       rd_en;
    logic [5:0] rd_addr;
    logic       wr_en;
    logic [5:0] wr_addr;
    logic       busy;
    logic       done;

    poly_mul_ctrl #(.LAT_NTT(5), .LAT_INTT(5), .LAT_MUL(3)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .sel(sel), .ntt_l(ntt_l), .tf_address(tf_address),
        .rd_en(rd_en), .rd_addr(rd_addr), .wr_en(wr_en), .wr_addr(wr_addr),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       rd_en;
        logic [5:0] rd_addr;
        logic       wr_en;
        logic [5:0] wr_addr;
        logic [2:0] sel;
        logic [1:0] ntt_l;
        logic [7:0] tf;
    } obs_t;

    typedef struct {
        logic [1:0] mode;
        logic [2:0] sel;
        int         l0, l1, l2;
        int         npass;
        int         lat;
        int         done_cyc;
    } vec_t;

    vec_t tbl [4];
    int   checks = 0;
    int   failures = 0;

    int         cur_lat, cur_n;
    int         cur_l [3];
    logic [2:0] cur_sel;
    logic       cur_mul;

    function automatic obs_t sample();
        obs_t a;
        a = '{busy, done, rd_en, rd_addr, wr_en, wr_addr, sel, ntt_l, tf_address};
        return a;
    endfunction

    // Expected outputs at cycle c after an accepted start (cycle 1 = first read)
    function automatic obs_t model_at(int c);
        obs_t e;
        int per, rel, p, off, w;
        e = '0;
        per = 64 + cur_lat;
        rel = c - 1;
        if (c >= 1 && rel < cur_n * per) begin
            p   = rel / per;
            off = rel % per;
            e.busy  = 1'b1;
            e.sel   = cur_sel;
            e.ntt_l = 2'(cur_l[p]);
            if (off < 64) begin
                e.rd_en   = 1'b1;
                e.rd_addr = 6'(off);
                if (cur_mul)             e.tf = 8'd0;
                else if (cur_l[p] == 0)  e.tf = 8'(off);
                else if (cur_l[p] == 1)  e.tf = 8'(63 + off / 2);
                else                     e.tf = 8'(127 + off / 2);
            end else begin
                e.rd_addr = 6'd63;
            end
        end
        if (c == 1 + cur_n * per) e.done = 1'b1;
        w = c - cur_lat;
        if (w >= 1 && (w - 1) < cur_n * per && ((w - 1) % per) < 64) begin
            e.wr_en   = 1'b1;
            e.wr_addr = 6'((w - 1) % per);
        end
        return e;
    endfunction

    // Ignore address fields whose strobe is inactive
    function automatic obs_t mask(obs_t a, obs_t e);
        obs_t m;
        m = a;
        if (!e.busy)  m.rd_addr = 6'd0;
        if (!e.rd_en) m.tf = 8'd0;
        if (!e.wr_en) m.wr_addr = 6'd0;
        return m;
    endfunction

    task automatic check(string name, int cyc, obs_t act, obs_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Idle cycles; strict requires every output bit zero
    task automatic idle_check(int n, bit strict);
        obs_t a, e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            a = sample();
            e = '0;
            check(strict ? "zero" : "idle", i, strict ? a : mask(a, e), e);
        end
    endtask

    // Start a run of table entry ti from the current negedge; check each cycle
    // up to stop_at (0 = through the cycle after done). Extra start pulses are
    // driven during cycles g0/g1/g2.
    task automatic run_seq(int ti, int g0, int g1, int g2, int stop_at);
        obs_t a, e;
        int last, done_seen;
        cur_lat = tbl[ti].lat;
        cur_n   = tbl[ti].npass;
        cur_l[0] = tbl[ti].l0;
        cur_l[1] = tbl[ti].l1;
        cur_l[2] = tbl[ti].l2;
        cur_sel = tbl[ti].sel;
        cur_mul = tbl[ti].mode[1];
        mode  = tbl[ti].mode;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mode  = 2'(~tbl[ti].mode);
        last = (stop_at > 0) ? stop_at : tbl[ti].done_cyc + 1;
        done_seen = 0;
        for (int c = 1; c <= last; c++) begin
            if (c > 1) @(negedge clk);
            a = sample();
            e = model_at(c);
            check("run", c, mask(a, e), e);
            if (a.done && done_seen == 0) done_seen = c;
            start = (c == g0 || c == g1 || c == g2) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        if (stop_at == 0) check_int("done_cycle", done_seen, tbl[ti].done_cyc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ti, gap;
        tbl[0] = '{2'b00, 3'b001, 0, 1, 2, 3, 5, 208};
        tbl[1] = '{2'b01, 3'b100, 2, 1, 0, 3, 5, 208};
        tbl[2] = '{2'b10, 3'b010, 2, 2, 2, 1, 3, 68};
        tbl[3] = '{2'b11, 3'b110, 2, 2, 2, 1, 3, 68};

        // Reset held three cycles, then quiet idle
        rst = 1'b0;
        idle_check(3, 1'b1);
        rst = 1'b1;
        idle_check(20, 1'b1);

        // Every mode once, default latencies
        for (int i = 0; i < 4; i++) begin
            run_seq(i, 0, 0, 0, 0);
            idle_check(2, 1'b0);
        end

        // Start pulses during a run and in DONE are ignored; the next IDLE cycle accepts
        run_seq(0, 10, 100, 208, 0);
        run_seq(0, 0, 0, 0, 0);
        idle_check(2, 1'b0);

        // Reset in the middle of pass 1, then a complete fresh run
        run_seq(0, 0, 0, 0, 75);
        rst = 1'b0;
        idle_check(3, 1'b1);
        rst = 1'b1;
        idle_check(3, 1'b1);
        run_seq(0, 0, 0, 0, 0);
        idle_check(1, 1'b0);

        // Randomized back-to-back runs with stray start pulses
        for (int k = 0; k < 12; k++) begin
            ti = int'($urandom_range(0, 3));
            run_seq(ti, int'($urandom_range(2, tbl[ti].done_cyc)),
                        int'($urandom_range(2, tbl[ti].done_cyc)),
                        int'($urandom_range(2, tbl[ti].done_cyc)), 0);
            gap = int'($urandom_range(0, 3));
            idle_check(gap, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/poly_mul_ctrl.md
# poly_mul_ctrl

Sequencer that drives the Dilithium polynomial arithmetic datapath (four-butterfly NTT/INTT/pointwise unit, 23-bit coefficients, two per 46-bit word). On a start request it walks the 64-word coefficient banks pass by pass, issuing read addresses, datapath mode (`sel`), layer select (`ntt_l`) and twiddle ROM address. It also produces latency-matched write-back addresses and enables. It sits between the top-level command register and the datapath/coefficient RAMs.

## Interface
Parameters:
- `LAT_NTT`, 5, read-to-write latency of the datapath in NTT mode (cycles, 1..8)
- `LAT_INTT`, 5, read-to-write latency in INTT mode (1..8)
- `LAT_MUL`, 3, read-to-write latency in MULT/ADD mode (1..8)

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-low
- `start`  in  1  one-cycle request; sampled only in IDLE
- `mode`  in  2  00 NTT, 01 INTT, 10 MULT, 11 ADD; sampled with `start`
- `sel`  out  3  datapath op: 001 NTT, 100 INTT, 010 MULT, 110 ADD, 000 idle
- `ntt_l`  out  2  layer group of current pass
- `tf_address`  out  8  twiddle ROM address
- `rd_en`  out  1  coefficient bank read strobe
- `rd_addr`  out  6  bank read word address
- `wr_en`  out  1  write-back strobe
- `wr_addr`  out  6  write-back word address
- `busy`  out  1  high from cycle after accepted `start` until `done`
- `done`  out  1  one-cycle completion pulse

## Operation
- Reset (`rst`=0 at posedge): state IDLE, all outputs 0, address/enable delay line cleared. Pending write-backs are discarded.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on `start`=1. Latch `mode`. Pass index p=0, counter cnt=0. `start` outside IDLE is ignored.
- Pass schedule:
  - NTT: 3 passes, `ntt_l`=0,1,2.
  - INTT: 3 passes, `ntt_l`=2,1,0.
  - MULT/ADD: 1 pass, `ntt_l`=2.
- RUN: 64 cycles with `rd_en`=1 and `rd_addr`=cnt, where cnt counts 0..63.
  - `tf_address`: `ntt_l`=0 gives cnt; `ntt_l`=1 gives 63+cnt[5:1]; `ntt_l`=2 gives 127+cnt[5:1]; MULT/ADD gives 0.
  - RUN -> DRAIN after cnt=63.
- DRAIN: LAT cycles with `rd_en`=0 and `rd_addr` held at 63. LAT is selected by the latched mode.
  - At DRAIN end: if more passes remain, go to RUN with p+1 and cnt=0; otherwise go to DONE.
- DONE: one cycle with `done`=1 and `busy`=0, then IDLE.
- `sel` and `ntt_l` are held constant through RUN and DRAIN of a pass, so the datapath's delayed output muxing stays valid. Both are 000/0 in IDLE and DONE.
- Write-back: `wr_en` and `wr_addr` are `rd_en` and `rd_addr` delayed by exactly LAT cycles through an 8-deep shift register tapped at LAT. Writes are in place (`wr_addr` equals the read address).
- No read of pass p+1 overlaps a write of pass p, so there is no RAM hazard.
- `tf_address` is 8-bit unsigned with no wrap; the maximum is 127+31=158.

## Timing
- `start` accepted at edge 0. First `rd_en` is at cycle 1 with `rd_addr`=0; `busy`=1 from cycle 1.
- Each pass takes 64+LAT cycles. The last read of a pass is at cycle T; its write is at T+LAT; the next pass's first read is at T+LAT+1.
- `done` is asserted at cycle 1 + passes×(64+LAT):
  - NTT/INTT with default LAT: cycle 208.
  - MULT/ADD with default LAT: cycle 68.
- The last `wr_en` is in the cycle before `done`. `wr_en` is never asserted in or after the DONE cycle.
- `start` asserted in the DONE cycle is ignored. `start` is accepted again from the first IDLE cycle.
- Reset mid-operation: outputs are 0 on the cycle after the reset edge, and no further `wr_en` occurs.

## Test plan
- Reset: hold `rst`=0 for 3 cycles, then release. Required: every output is 0, and stays 0 with `start`=0 for 20 cycles.
- NTT (`mode`=00, default LAT):
  - `rd_addr` sweeps 0..63 at cycles 1–64, 70–133 and 139–202.
  - `ntt_l` is 0/1/2 per pass, with `sel`=001 throughout.
  - `tf_address` is 0..63 in pass 0, 63..94 (each value twice) in pass 1, and 127..158 in pass 2.
  - `wr_addr` equals `rd_addr` 5 cycles earlier.
  - `done` at cycle 208 only.
- INTT (`mode`=01): `sel`=100, `ntt_l` order 2,1,0, `done` at cycle 208.
- MULT (`mode`=10) with `LAT_MUL`=3:
  - Single pass, `sel`=010, `ntt_l`=2, `tf_address`=0.
  - `wr_en` at cycles 4..67; `done` at cycle 68.
  - ADD (`mode`=11): same timing with `sel`=110.
- `start` pulses at cycles 10, 100 and 208 during an NTT run. Required: no restart and unchanged sequence. A `start` at cycle 209 is accepted.
- `rst`=0 at cycle 75 of an NTT run. Required: `rd_en`, `wr_en`, `sel`, `busy` are 0 from cycle 76, and a new `start` afterwards runs a full sequence from `rd_addr`=0.
